// File: rtl/approx_mul_pkg.sv
// Shared constants for the approximate-multiplier sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a. Optional cycle counter is enabled by APPROX_MUL_CTRL_CYC_EN.
package approx_mul_pkg;

   // 4-bit binary state encoding of the control FSM
   localparam logic [3:0] IDLE = 4'd0;
   localparam logic [3:0] INIT = 4'd1;
   localparam logic [3:0] PREP = 4'd2;
   localparam logic [3:0] LD_A = 4'd3;
   localparam logic [3:0] SH_A = 4'd4;
   localparam logic [3:0] ST_A = 4'd5;
   localparam logic [3:0] LD_B = 4'd6;
   localparam logic [3:0] SH_B = 4'd7;
   localparam logic [3:0] ST_B = 4'd8;
   localparam logic [3:0] LD_R = 4'd9;
   localparam logic [3:0] SH_R = 4'd10;
   localparam logic [3:0] WR   = 4'd11;
   localparam logic [3:0] DONE = 4'd12;

   // operand mux select
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // default width of the run-length counter
   localparam int CW_DEF = 16;

endpackage

// File: rtl/approx_mul_cyc_cnt.sv
// Saturating busy-cycle counter used to measure the length of one run.
// Latency: count visible one cycle after the counted cycle.
// Backpressure: none; sticks at all-ones instead of wrapping. Built only with APPROX_MUL_CTRL_CYC_EN.
`ifdef APPROX_MUL_CTRL_CYC_EN
module approx_mul_cyc_cnt
   import approx_mul_pkg::*;
#(
   parameter int CW = CW_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt
);

   // clear has priority; increment stops at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/approx_mul_ctrl.sv
// Control FSM sequencing load/normalise/multiply/denormalise/write over every input RAM pair.
// Latency: 10 + sA + sB + sR cycles per pair, plus 3 per run (INIT, DONE, IDLE exit).
// Backpressure: start is only sampled in IDLE; optional run-length output under APPROX_MUL_CTRL_CYC_EN.
module approx_mul_ctrl
   import approx_mul_pkg::*;
`ifdef APPROX_MUL_CTRL_CYC_EN
#(
   parameter int CW = CW_DEF
)
`endif
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          check_sh,
   input  logic          ov_cnt32,
   input  logic          ov,
   output logic          clr,
   output logic          clrA,
   output logic          clrB,
   output logic          cnten,
   output logic          cntenA,
   output logic          cntenB,
   output logic          ldcnt,
   output logic          ldshA,
   output logic          ldshB,
   output logic          shenA,
   output logic          shenB,
   output logic          sel,
   output logic          enA,
   output logic          enB,
   output logic          inpRAMen,
   output logic          outRAMen,
   output logic          done,
`ifdef APPROX_MUL_CTRL_CYC_EN
   output logic          busy,
   output logic [CW-1:0] cycles
`else
   output logic          busy
`endif
);

   logic [3:0] state;
   logic [3:0] state_nxt;

   // state register; reset abandons any run in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and output decode; shift enables are gated by the exit condition in the same cycle
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      clrA      = 1'b0;
      clrB      = 1'b0;
      cnten     = 1'b0;
      cntenA    = 1'b0;
      cntenB    = 1'b0;
      ldcnt     = 1'b0;
      ldshA     = 1'b0;
      ldshB     = 1'b0;
      shenA     = 1'b0;
      shenB     = 1'b0;
      sel       = SEL_A;
      enA       = 1'b0;
      enB       = 1'b0;
      inpRAMen  = 1'b0;
      outRAMen  = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = INIT;
         INIT: begin
            clr       = 1'b1;
            inpRAMen  = 1'b1;
            state_nxt = PREP;
         end
         PREP: begin
            clrA      = 1'b1;
            clrB      = 1'b1;
            state_nxt = LD_A;
         end
         LD_A: begin
            sel       = SEL_A;
            ldshA     = 1'b1;
            state_nxt = SH_A;
         end
         SH_A: begin
            if (check_sh) begin
               state_nxt = ST_A;
            end else begin
               shenA  = 1'b1;
               cntenA = 1'b1;
            end
         end
         ST_A: begin
            enA       = 1'b1;
            state_nxt = LD_B;
         end
         // second operand reuses the A-side shifter and worthless-bit counter
         LD_B: begin
            sel       = SEL_B;
            ldshA     = 1'b1;
            clrB      = 1'b1;
            state_nxt = SH_B;
         end
         SH_B: begin
            if (check_sh) begin
               state_nxt = ST_B;
            end else begin
               shenA  = 1'b1;
               cntenA = 1'b1;
            end
         end
         ST_B: begin
            enB       = 1'b1;
            state_nxt = LD_R;
         end
         LD_R: begin
            ldshB     = 1'b1;
            ldcnt     = 1'b1;
            state_nxt = SH_R;
         end
         SH_R: begin
            if (ov_cnt32) begin
               state_nxt = WR;
            end else begin
               shenB  = 1'b1;
               cntenB = 1'b1;
            end
         end
         WR: begin
            outRAMen = 1'b1;
            if (ov) begin
               state_nxt = DONE;
            end else begin
               cnten     = 1'b1;
               state_nxt = PREP;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef APPROX_MUL_CTRL_CYC_EN
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] cyc_p1;
   logic [CW-1:0] cyc_p2;
   logic          cyc_clr;

   // counter reads 0 throughout INIT, then counts every busy cycle
   assign cyc_clr = (state == IDLE) && start;

   approx_mul_cyc_cnt #(
      .CW (CW)
   ) u_cyc_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cyc_clr),
      .inc (busy),
      .cnt (cyc_cnt)
   );

   // in the final WR the counter holds the cycles before WR; add WR and DONE, saturating
   assign cyc_p1 = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
   assign cyc_p2 = (cyc_p1  == '1) ? cyc_p1  : cyc_p1  + 1'b1;

   // publish the run length on entry to DONE and hold it until the next run finishes
   always_ff @(posedge clk) begin
      if (rst) begin
         cycles <= '0;
      end else if ((state == WR) && ov) begin
         cycles <= cyc_p2;
      end
   end
`endif

endmodule

// File: tb/tb_approx_mul_ctrl.sv
// Bench for approx_mul_ctrl: expands operand pairs into expected per-cycle output vectors.
// Latency: n/a.
// Backpressure: n/a. Run-length checks are included when APPROX_MUL_CTRL_CYC_EN is defined.
module tb_approx_mul_ctrl;

   logic clk;
   logic rst, start, check_sh, ov_cnt32, ov;
   logic clr, clrA, clrB, cnten, cntenA, cntenB, ldcnt, ldshA, ldshB;
   logic shenA, shenB, sel, enA, enB, inpRAMen, outRAMen, done, busy;
`ifdef APPROX_MUL_CTRL_CYC_EN
   logic [15:0] cycles;
`endif

   approx_mul_ctrl dut (
      .clk (clk), .rst (rst), .start (start), .check_sh (check_sh),
      .ov_cnt32 (ov_cnt32), .ov (ov),
      .clr (clr), .clrA (clrA), .clrB (clrB), .cnten (cnten),
      .cntenA (cntenA), .cntenB (cntenB), .ldcnt (ldcnt),
      .ldshA (ldshA), .ldshB (ldshB), .shenA (shenA), .shenB (shenB),
      .sel (sel), .enA (enA), .enB (enB), .inpRAMen (inpRAMen),
      .outRAMen (outRAMen), .done (done),
`ifdef APPROX_MUL_CTRL_CYC_EN
      .busy (busy), .cycles (cycles)
`else
      .busy (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int I_CLR = 17, I_CLRA = 16, I_CLRB = 15, I_CNTEN = 14, I_CNTENA = 13;
   localparam int I_CNTENB = 12, I_LDCNT = 11, I_LDSHA = 10, I_LDSHB = 9, I_SHENA = 8;
   localparam int I_SHENB = 7, I_SEL = 6, I_ENA = 5, I_ENB = 4, I_INP = 3, I_OUT = 2;
   localparam int I_DONE = 1, I_BUSY = 0;

   localparam logic [17:0] O_CLR    = 18'd1 << I_CLR;
   localparam logic [17:0] O_CLRA   = 18'd1 << I_CLRA;
   localparam logic [17:0] O_CLRB   = 18'd1 << I_CLRB;
   localparam logic [17:0] O_CNTEN  = 18'd1 << I_CNTEN;
   localparam logic [17:0] O_CNTENA = 18'd1 << I_CNTENA;
   localparam logic [17:0] O_CNTENB = 18'd1 << I_CNTENB;
   localparam logic [17:0] O_LDCNT  = 18'd1 << I_LDCNT;
   localparam logic [17:0] O_LDSHA  = 18'd1 << I_LDSHA;
   localparam logic [17:0] O_LDSHB  = 18'd1 << I_LDSHB;
   localparam logic [17:0] O_SHENA  = 18'd1 << I_SHENA;
   localparam logic [17:0] O_SHENB  = 18'd1 << I_SHENB;
   localparam logic [17:0] O_SEL    = 18'd1 << I_SEL;
   localparam logic [17:0] O_ENA    = 18'd1 << I_ENA;
   localparam logic [17:0] O_ENB    = 18'd1 << I_ENB;
   localparam logic [17:0] O_INP    = 18'd1 << I_INP;
   localparam logic [17:0] O_OUT    = 18'd1 << I_OUT;
   localparam logic [17:0] O_DONE   = 18'd1 << I_DONE;
   localparam logic [17:0] O_BUSY   = 18'd1 << I_BUSY;

   logic [17:0] dut_o;
   assign dut_o = {clr, clrA, clrB, cnten, cntenA, cntenB, ldcnt, ldshA, ldshB,
                   shenA, shenB, sel, enA, enB, inpRAMen, outRAMen, done, busy};

   typedef struct {
      bit          rst;
      bit          start;
      bit          check_sh;
      bit          ov_cnt32;
      bit          ov;
      logic [17:0] exp;
      int          tag;
   } rec_t;

   rec_t        q[$];
   rec_t        cur;
   bit          cur_vld;
   logic [15:0] pa[$];
   logic [15:0] pb[$];
   int          psr[$];
   bit          g_hold;
   int          g_tag;
   int          checks;
   int          errors;
   int          n_out[8], n_cnten[8], n_done[8], n_shena[8], n_ldcnt[8], n_ena[8], n_clra[8];

   // normalisation shifts: leading zeros, or 15 when the 16-bit shift count overflows first
   function automatic int shifts_for(logic [15:0] v);
      for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
      return 15;
   endfunction

   task automatic push(bit r, bit s, bit cs, bit oc, bit o, logic [17:0] e);
      rec_t x;
      x.rst = r; x.start = s; x.check_sh = cs; x.ov_cnt32 = oc; x.ov = o;
      x.exp = e; x.tag = g_tag;
      q.push_back(x);
   endtask

   task automatic pr(bit cs, bit oc, bit o, logic [17:0] e);
      push(1'b0, g_hold, cs, oc, o, e | O_BUSY);
   endtask

   // one run over n queued pairs; abort resets in the first SH_R shift cycle
   task automatic add_run(int n, bit hold, int tag, bit abort);
      int sa, sb, sr;
      bit last;
      g_hold = hold;
      g_tag  = tag;
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
      pr(0, 0, 0, O_CLR | O_INP);
      for (int i = 0; i < n; i++) begin
         sa = shifts_for(pa.pop_front());
         sb = shifts_for(pb.pop_front());
         sr = psr.pop_front();
         last = (i == n - 1);
         pr(0, 0, 0, O_CLRA | O_CLRB);
         pr(0, 0, 0, O_LDSHA);
         repeat (sa) pr(0, 0, 0, O_SHENA | O_CNTENA);
         pr(1, 0, 0, 18'd0);
         pr(0, 0, 0, O_ENA);
         pr(0, 0, 0, O_SEL | O_LDSHA | O_CLRB);
         repeat (sb) pr(0, 0, 0, O_SHENA | O_CNTENA);
         pr(1, 0, 0, 18'd0);
         pr(0, 0, 0, O_ENB);
         pr(0, 0, 0, O_LDSHB | O_LDCNT);
         if (abort) begin
            push(1'b1, hold, 1'b0, 1'b0, 1'b0, O_SHENB | O_CNTENB | O_BUSY);
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0);
            return;
         end
         repeat (sr) pr(0, 0, 0, O_SHENB | O_CNTENB);
         pr(0, 1, 0, 18'd0);
         pr(0, 0, last, O_OUT | (last ? 18'd0 : O_CNTEN));
      end
      pr(0, 0, 0, O_DONE);
   endtask

   task automatic drive_all();
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         cur      = q.pop_front();
         rst      = cur.rst;
         start    = cur.start;
         check_sh = cur.check_sh;
         ov_cnt32 = cur.ov_cnt32;
         ov       = cur.ov;
         cur_vld  = 1'b1;
      end
      @(posedge clk);
      #1;
      cur_vld = 1'b0;
      rst = 1'b0; start = 1'b0; check_sh = 1'b0; ov_cnt32 = 1'b0; ov = 1'b0;
   endtask

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // per-cycle comparison of every output against the expanded model
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (cur_vld) begin
            checks++;
            if (dut_o !== cur.exp) begin
               errors++;
               $display("FAIL outputs tag=%0d t=%0t actual=%b required=%b",
                        cur.tag, $time, dut_o, cur.exp);
            end
            if (dut_o[I_OUT])   n_out[cur.tag]++;
            if (dut_o[I_CNTEN]) n_cnten[cur.tag]++;
            if (dut_o[I_DONE])  n_done[cur.tag]++;
            if (dut_o[I_SHENA]) n_shena[cur.tag]++;
            if (dut_o[I_LDCNT]) n_ldcnt[cur.tag]++;
            if (dut_o[I_ENA])   n_ena[cur.tag]++;
            if (dut_o[I_CLRA])  n_clra[cur.tag]++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; check_sh = 1'b0; ov_cnt32 = 1'b0; ov = 1'b0;
      cur_vld = 1'b0; checks = 0; errors = 0;
      for (int i = 0; i < 8; i++) begin
         n_out[i] = 0; n_cnten[i] = 0; n_done[i] = 0; n_shena[i] = 0;
         n_ldcnt[i] = 0; n_ena[i] = 0; n_clra[i] = 0;
      end
      fork
         compare_loop();
      join_none

      // reset held two cycles with start high, then idle
      g_tag = 0; g_hold = 1'b0;
      push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
      push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0);
      drive_all();
`ifdef APPROX_MUL_CTRL_CYC_EN
      chk("cycles_reset", int'(cycles), 0);
`endif

      // single pair 0x4000 x 0x8000: one A shift, no B shift, one R shift
      pa.push_back(16'h4000); pb.push_back(16'h8000); psr.push_back(1);
      add_run(1, 1'b0, 1, 1'b0);
      chk("model_len_pair1", q.size(), 15);
      drive_all();
      chk("pair1_shenA", n_shena[1], 1);
      chk("pair1_ldcnt", n_ldcnt[1], 1);
      chk("pair1_outRAMen", n_out[1], 1);
      chk("pair1_done", n_done[1], 1);
      chk("pair1_cnten", n_cnten[1], 0);

      // zero operand: normalisation ends only on shift-count overflow
      pa.push_back(16'h0000); pb.push_back(16'h8000); psr.push_back(0);
      add_run(1, 1'b0, 2, 1'b0);
      chk("model_len_zero", q.size(), 28);
      drive_all();
      chk("zero_shenA", n_shena[2], 15);
      chk("zero_enA", n_ena[2], 1);

      // sixteen pairs with assorted shift counts
      for (int i = 0; i < 16; i++) begin
         pa.push_back(16'h8000 >> (i % 4));
         pb.push_back(16'hC000 >> ((i * 3) % 5));
         psr.push_back(i % 3);
      end
      add_run(16, 1'b0, 3, 1'b0);
      drive_all();
      chk("run16_outRAMen", n_out[3], 16);
      chk("run16_cnten", n_cnten[3], 15);
      chk("run16_done", n_done[3], 1);
      chk("run16_clrA", n_clra[3], 16);

      // start held high throughout: ignored while busy, restarts after DONE
      pa.push_back(16'h8000); pb.push_back(16'h8000); psr.push_back(0);
      pa.push_back(16'h1000); pb.push_back(16'h4000); psr.push_back(2);
      pa.push_back(16'h2000); pb.push_back(16'h0800); psr.push_back(1);
      add_run(2, 1'b1, 4, 1'b0);
      add_run(1, 1'b1, 4, 1'b0);
      drive_all();
      chk("held_start_done", n_done[4], 2);
      chk("held_start_outRAMen", n_out[4], 3);

      // reset during an R shift, then a clean rerun
      pa.push_back(16'h4000); pb.push_back(16'h8000); psr.push_back(2);
      add_run(1, 1'b0, 5, 1'b1);
      pa.push_back(16'hFFFF); pb.push_back(16'h0100); psr.push_back(1);
      add_run(1, 1'b0, 6, 1'b0);
      drive_all();
      chk("abort_outRAMen", n_out[5], 0);
      chk("abort_done", n_done[5], 0);
      chk("rerun_done", n_done[6], 1);

      // run length: sA = sB = sR = 2 on one pair
      pa.push_back(16'h2000); pb.push_back(16'h2000); psr.push_back(2);
      add_run(1, 1'b0, 7, 1'b0);
      drive_all();
      chk("len_done", n_done[7], 1);
`ifdef APPROX_MUL_CTRL_CYC_EN
      chk("cycles_run", int'(cycles), 18);
      repeat (5) @(posedge clk);
      #1;
      chk("cycles_hold", int'(cycles), 18);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
